ptp_hw_assist: RTL and testbench

//  Single-clock IEEE-1588 (PTP) hardware assist: free-running real-time clock (RTC) with
//  48b seconds / 30b ns, plus RX and TX GMII timestamp units (TSUs) stamping PTP event frames.

---
 rtl/ptp_hw_assist_pkg.sv | 45 ++++
 rtl/ptp_hw_assist_tsu.sv | 150 +++++++++++++++
 rtl/ptp_hw_assist.sv | 184 ++++++++++++++++++
 tb/tb_ptp_hw_assist.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_hw_assist_pkg.sv
// ptp_hw_assist_pkg: register map, CTRL bits and framing constants
// shared by the PTP RTC top and its timestamp units.
package ptp_hw_assist_pkg;

  localparam logic [7:0] A_CTRL    = 8'h00;
  localparam logic [7:0] A_PERIOD  = 8'h08;
  localparam logic [7:0] A_ADJ     = 8'h0C;
  localparam logic [7:0] A_SET_HI  = 8'h10;
  localparam logic [7:0] A_SET_LO  = 8'h14;
  localparam logic [7:0] A_SET_NS  = 8'h18;
  localparam logic [7:0] A_RX_ST   = 8'h20;
  localparam logic [7:0] A_RX_HI   = 8'h24;
  localparam logic [7:0] A_RX_LO   = 8'h28;
  localparam logic [7:0] A_RX_NS   = 8'h2C;
  localparam logic [7:0] A_TX_ST   = 8'h30;
  localparam logic [7:0] A_TX_HI   = 8'h34;
  localparam logic [7:0] A_TX_LO   = 8'h38;
  localparam logic [7:0] A_TX_NS   = 8'h3C;
  localparam logic [7:0] A_SNAP_HI = 8'h40;
  localparam logic [7:0] A_SNAP_LO = 8'h44;
  localparam logic [7:0] A_SNAP_NS = 8'h48;

  localparam int C_SET    = 0;
  localparam int C_ADJ    = 1;
  localparam int C_PER    = 2;
  localparam int C_SNAP   = 3;
  localparam int C_CLR_RX = 4;
  localparam int C_CLR_TX = 5;

  localparam logic signed [32:0] NS_PER_SEC =
    33'sd1_000_000_000;
  localparam logic [29:0] NS_PER_SEC30 =
    30'd1_000_000_000;

  localparam logic [15:0] ETH_PTP  = 16'h88F7;
  localparam logic [7:0]  SFD      = 8'hD5;
  localparam logic [7:0]  PREAMBLE = 8'h55;

  typedef enum logic [1:0] {
    TSU_IDLE,
    TSU_PRE,
    TSU_FRAME
  } tsu_state_e;

endpackage

// File: rtl/ptp_hw_assist_tsu.sv
// ptp_tsu: GMII/MII tap that stamps PTP event frames at SFD time
// and holds the result until the host clears it.
module ptp_tsu
  import ptp_hw_assist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        ctrl_i,
  input  logic [7:0]  data_i,
  input  logic        giga_i,
  input  logic [47:0] sec_i,
  input  logic [29:0] ns_i,
  input  logic        clr_i,
  output logic        valid_o,
  output logic        ovf_o,
  output logic [15:0] seq_o,
  output logic [47:0] sec_o,
  output logic [29:0] ns_o
);

  logic       half_q;
  logic [3:0] lo_q;
  logic       bv;
  logic [7:0] b;

  tsu_state_e  st_q, st_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ok_q, ok_d;
  logic [15:0] seq_q, seq_d;
  logic [47:0] ssec_q, ssec_d;
  logic [29:0] sns_q, sns_d;
  logic        done;

  logic        v_q, o_q;
  logic [15:0] lseq_q;
  logic [47:0] lsec_q;
  logic [29:0] lns_q;

  // MII: low nibble arrives first, byte completes on the high one
  always_comb begin
    bv = ctrl_i & (giga_i | half_q);
    b  = giga_i ? data_i : {data_i[3:0], lo_q};
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q <= 1'b0;
      lo_q   <= '0;
    end else if (!ctrl_i || giga_i) begin
      half_q <= 1'b0;
    end else begin
      half_q <= ~half_q;
      if (!half_q) lo_q <= data_i[3:0];
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    ok_d   = ok_q;
    seq_d  = seq_q;
    ssec_d = ssec_q;
    sns_d  = sns_q;
    done   = 1'b0;
    unique case (st_q)
      TSU_IDLE: begin
        if (bv && b == PREAMBLE) st_d = TSU_PRE;
      end
      TSU_PRE: begin
        if (!ctrl_i) begin
          st_d = TSU_IDLE;
        end else if (bv) begin
          if (b == SFD) begin
            st_d   = TSU_FRAME;
            cnt_d  = '0;
            ok_d   = 1'b1;
            ssec_d = sec_i;
            sns_d  = ns_i;
          end else if (b != PREAMBLE) begin
            st_d = TSU_IDLE;
          end
        end
      end
      TSU_FRAME: begin
        if (!ctrl_i) begin
          st_d = TSU_IDLE;
          done = ok_q && (cnt_q >= 6'd46);
        end else if (bv) begin
          if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd12 && b != ETH_PTP[15:8])
            ok_d = 1'b0;
          if (cnt_q == 6'd13 && b != ETH_PTP[7:0])
            ok_d = 1'b0;
          if (cnt_q == 6'd14 && b[3:2] != 2'b00)
            ok_d = 1'b0;
          if (cnt_q == 6'd44) seq_d[15:8] = b;
          if (cnt_q == 6'd45) seq_d[7:0]  = b;
        end
      end
      default: st_d = TSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= TSU_IDLE;
      cnt_q  <= '0;
      ok_q   <= 1'b0;
      seq_q  <= '0;
      ssec_q <= '0;
      sns_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      ok_q   <= ok_d;
      seq_q  <= seq_d;
      ssec_q <= ssec_d;
      sns_q  <= sns_d;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= 1'b0;
      o_q    <= 1'b0;
      lseq_q <= '0;
      lsec_q <= '0;
      lns_q  <= '0;
    end else if (clr_i) begin
      v_q <= 1'b0;
      o_q <= 1'b0;
    end else if (done) begin
      if (v_q) begin
        o_q <= 1'b1;
      end else begin
        v_q    <= 1'b1;
        lseq_q <= seq_q;
        lsec_q <= ssec_q;
        lns_q  <= sns_q;
      end
    end
  end

  assign valid_o = v_q;
  assign ovf_o   = o_q;
  assign seq_o   = lseq_q;
  assign sec_o   = lsec_q;
  assign ns_o    = lns_q;

endmodule

// File: rtl/ptp_hw_assist.sv
// ptp_hw_assist: free-running PTP RTC, host register port and
// RX/TX timestamp units.
module ptp_hw_assist
  import ptp_hw_assist_pkg::*;
#(
  parameter logic [31:0] DEFAULT_PERIOD = 32'h0800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_in,
  input  logic        rd_in,
  input  logic [7:0]  addr_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [31:0] rtc_time_ptp_ns,
  output logic [47:0] rtc_time_ptp_sec,
  output logic        rtc_time_one_pps,
  input  logic        rx_gmii_ctrl,
  input  logic [7:0]  rx_gmii_data,
  input  logic        rx_giga_mode,
  input  logic        tx_gmii_ctrl,
  input  logic [7:0]  tx_gmii_data,
  input  logic        tx_giga_mode
);

  logic [7:0]  a;
  logic        wr_ctrl;
  logic        do_set, do_adj, do_per;
  logic        do_snap, clr_rx, clr_tx;

  logic [29:0] ns_q, ns_d;
  logic [23:0] frac_q, frac_d;
  logic [47:0] sec_q, sec_d;
  logic        pps_q, pps_d;

  logic [31:0] period_q, pnext_q, adj_q, set_lo_q;
  logic [15:0] set_hi_q;
  logic [29:0] set_ns_q;
  logic [47:0] snap_sec_q;
  logic [29:0] snap_ns_q;
  logic [31:0] rdata, dout_q;

  logic [29:0] base_ns;
  logic [23:0] base_frac;
  logic [47:0] base_sec;
  logic [54:0] sum;
  logic signed [32:0] tot;

  logic        rx_vld, rx_ovf, tx_vld, tx_ovf;
  logic [15:0] rx_seq, tx_seq;
  logic [47:0] rx_sec, tx_sec;
  logic [29:0] rx_ns, tx_ns;

  assign a       = addr_in & 8'hFC;
  assign wr_ctrl = wr_in && (a == A_CTRL);
  assign do_set  = wr_ctrl & data_in[C_SET];
  assign do_adj  = wr_ctrl & data_in[C_ADJ];
  assign do_per  = wr_ctrl & data_in[C_PER];
  assign do_snap = wr_ctrl & data_in[C_SNAP];
  assign clr_rx  = wr_ctrl & data_in[C_CLR_RX];
  assign clr_tx  = wr_ctrl & data_in[C_CLR_TX];

  // set, adjust and this clock's increment fold into one wrap step
  always_comb begin
    base_ns   = do_set ? set_ns_q : ns_q;
    base_frac = do_set ? 24'd0 : frac_q;
    base_sec  = do_set ? {set_hi_q, set_lo_q} : sec_q;
    sum = {1'b0, base_ns, base_frac} + {23'd0, period_q};
    tot = $signed({2'b00, sum[54:24]}) +
          (do_adj ? $signed({adj_q[31], adj_q}) : 33'sd0);
    frac_d = sum[23:0];
    ns_d   = tot[29:0];
    sec_d  = base_sec;
    pps_d  = 1'b0;
    if (tot >= NS_PER_SEC) begin
      ns_d  = tot[29:0] - NS_PER_SEC30;
      sec_d = base_sec + 48'd1;
      pps_d = 1'b1;
    end else if (tot < 33'sd0) begin
      ns_d  = tot[29:0] + NS_PER_SEC30;
      sec_d = base_sec - 48'd1;
    end
  end

  always_comb begin
    rdata = '0;
    case (a)
      A_PERIOD:  rdata = pnext_q;
      A_ADJ:     rdata = adj_q;
      A_SET_HI:  rdata = {16'd0, set_hi_q};
      A_SET_LO:  rdata = set_lo_q;
      A_SET_NS:  rdata = {2'd0, set_ns_q};
      A_RX_ST:   rdata = {rx_seq, 14'd0, rx_ovf, rx_vld};
      A_RX_HI:   rdata = {16'd0, rx_sec[47:32]};
      A_RX_LO:   rdata = rx_sec[31:0];
      A_RX_NS:   rdata = {2'd0, rx_ns};
      A_TX_ST:   rdata = {tx_seq, 14'd0, tx_ovf, tx_vld};
      A_TX_HI:   rdata = {16'd0, tx_sec[47:32]};
      A_TX_LO:   rdata = tx_sec[31:0];
      A_TX_NS:   rdata = {2'd0, tx_ns};
      A_SNAP_HI: rdata = {16'd0, snap_sec_q[47:32]};
      A_SNAP_LO: rdata = snap_sec_q[31:0];
      A_SNAP_NS: rdata = {2'd0, snap_ns_q};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ns_q       <= '0;
      frac_q     <= '0;
      sec_q      <= '0;
      pps_q      <= 1'b0;
      period_q   <= DEFAULT_PERIOD;
      pnext_q    <= DEFAULT_PERIOD;
      adj_q      <= '0;
      set_hi_q   <= '0;
      set_lo_q   <= '0;
      set_ns_q   <= '0;
      snap_sec_q <= '0;
      snap_ns_q  <= '0;
      dout_q     <= '0;
    end else begin
      ns_q   <= ns_d;
      frac_q <= frac_d;
      sec_q  <= sec_d;
      pps_q  <= pps_d;
      if (do_per) period_q <= pnext_q;
      if (do_snap) begin
        snap_sec_q <= sec_q;
        snap_ns_q  <= ns_q;
      end
      if (wr_in) begin
        case (a)
          A_PERIOD: pnext_q  <= data_in;
          A_ADJ:    adj_q    <= data_in;
          A_SET_HI: set_hi_q <= data_in[15:0];
          A_SET_LO: set_lo_q <= data_in;
          A_SET_NS: set_ns_q <= data_in[29:0];
          default: ;
        endcase
      end
      if (rd_in) dout_q <= rdata;
    end
  end

  ptp_tsu u_rx (
    .clk     (clk),
    .rst_ni  (rst),
    .ctrl_i  (rx_gmii_ctrl),
    .data_i  (rx_gmii_data),
    .giga_i  (rx_giga_mode),
    .sec_i   (sec_q),
    .ns_i    (ns_q),
    .clr_i   (clr_rx),
    .valid_o (rx_vld),
    .ovf_o   (rx_ovf),
    .seq_o   (rx_seq),
    .sec_o   (rx_sec),
    .ns_o    (rx_ns)
  );

  ptp_tsu u_tx (
    .clk     (clk),
    .rst_ni  (rst),
    .ctrl_i  (tx_gmii_ctrl),
    .data_i  (tx_gmii_data),
    .giga_i  (tx_giga_mode),
    .sec_i   (sec_q),
    .ns_i    (ns_q),
    .clr_i   (clr_tx),
    .valid_o (tx_vld),
    .ovf_o   (tx_ovf),
    .seq_o   (tx_seq),
    .sec_o   (tx_sec),
    .ns_o    (tx_ns)
  );

  assign data_out         = dout_q;
  assign rtc_time_ptp_ns  = {2'b00, ns_q};
  assign rtc_time_ptp_sec = sec_q;
  assign rtc_time_one_pps = pps_q;

endmodule

// File: tb/tb_ptp_hw_assist.sv
// tb_ptp_hw_assist: register table plus directed RTC and
// timestamp-unit sequences for ptp_hw_assist.
module tb_ptp_hw_assist;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_in = 1'b0;
  logic        rd_in = 1'b0;
  logic [7:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [31:0] rtc_ns;
  logic [47:0] rtc_sec;
  logic        pps;
  logic        rx_ctrl = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ctrl = 1'b0;
  logic [7:0]  tx_data = '0;

  ptp_hw_assist dut (
    .clk              (clk),
    .rst              (rst),
    .wr_in            (wr_in),
    .rd_in            (rd_in),
    .addr_in          (addr_in),
    .data_in          (data_in),
    .data_out         (data_out),
    .rtc_time_ptp_ns  (rtc_ns),
    .rtc_time_ptp_sec (rtc_sec),
    .rtc_time_one_pps (pps),
    .rx_gmii_ctrl     (rx_ctrl),
    .rx_gmii_data     (rx_data),
    .rx_giga_mode     (1'b1),
    .tx_gmii_ctrl     (tx_ctrl),
    .tx_gmii_data     (tx_data),
    .tx_giga_mode     (1'b0)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t vt [14];
  logic [7:0] frm [0:127];
  int flen;
  logic [31:0] rv;
  int npps;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] ad, input logic [31:0] d);
    @(negedge clk);
    wr_in = 1'b1; addr_in = ad; data_in = d;
    @(negedge clk);
    wr_in = 1'b0;
  endtask

  task automatic rd(input logic [7:0] ad, output logic [31:0] d);
    @(negedge clk);
    rd_in = 1'b1; addr_in = ad;
    @(negedge clk);
    rd_in = 1'b0;
    d = data_out;
  endtask

  task automatic set_time(input logic [15:0] hi,
                          input logic [31:0] lo,
                          input logic [31:0] ns);
    wr(8'h10, {16'd0, hi});
    wr(8'h14, lo);
    wr(8'h18, ns);
  endtask

  task automatic build(input logic [15:0] et, input logic [3:0] mt,
                       input logic [15:0] sq, input int len);
    for (int i = 0; i < 7; i++) frm[i] = 8'h55;
    frm[7] = 8'hD5;
    for (int k = 0; k < len; k++) frm[8+k] = 8'(k + 1);
    frm[20] = et[15:8];
    frm[21] = et[7:0];
    frm[22] = {4'h0, mt};
    frm[52] = sq[15:8];
    frm[53] = sq[7:0];
    flen = 8 + len;
  endtask

  // tx uses MII nibbles with junk in the upper bits
  task automatic send(input bit tx);
    for (int i = 0; i < flen; i++) begin
      if (tx) begin
        @(negedge clk);
        tx_ctrl = 1'b1; tx_data = {4'hA, frm[i][3:0]};
        @(negedge clk);
        tx_data = {4'h5, frm[i][7:4]};
      end else begin
        @(negedge clk);
        rx_ctrl = 1'b1; rx_data = frm[i];
      end
    end
    @(negedge clk);
    rx_ctrl = 1'b0; tx_ctrl = 1'b0;
    rx_data = '0;   tx_data = '0;
    @(negedge clk);
  endtask

  initial begin
    vt[0]  = '{1'b0, 8'h00, 32'h0,         32'h0};
    vt[1]  = '{1'b0, 8'h08, 32'h0,         32'h0800_0000};
    vt[2]  = '{1'b0, 8'h0C, 32'h0,         32'h0};
    vt[3]  = '{1'b0, 8'h20, 32'h0,         32'h0};
    vt[4]  = '{1'b0, 8'h30, 32'h0,         32'h0};
    vt[5]  = '{1'b0, 8'h44, 32'h0,         32'h0};
    vt[6]  = '{1'b1, 8'h0C, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    vt[7]  = '{1'b1, 8'h10, 32'hABCD_1234, 32'h0000_1234};
    vt[8]  = '{1'b1, 8'h18, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vt[9]  = '{1'b1, 8'h14, 32'h1357_9BDF, 32'h1357_9BDF};
    vt[10] = '{1'b1, 8'h50, 32'hDEAD_BEEF, 32'h0};
    vt[11] = '{1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0};
    vt[12] = '{1'b0, 8'h0F, 32'h0,         32'hFFFF_FFF0};
    vt[13] = '{1'b1, 8'h0C, 32'h0,         32'h0};

    repeat (3) @(negedge clk);
    chk("rst_ns", 64'(rtc_ns), 0);
    chk("rst_sec", 64'(rtc_sec), 0);
    chk("rst_pps", 64'(pps), 0);
    chk("rst_dout", 64'(data_out), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_inc", 64'(rtc_ns), 8);

    for (int i = 0; i < 14; i++) begin
      if (vt[i].wr) wr(vt[i].a, vt[i].d);
      rd(vt[i].a, rv);
      chk($sformatf("reg_vec%0d", i), 64'(rv), 64'(vt[i].e));
    end

    // SET lands one increment before rollover
    set_time(16'h0, 32'd5, 32'd999_999_992);
    wr(8'h00, 32'h1);
    chk("set_roll_sec", 64'(rtc_sec), 6);
    chk("set_roll_ns", 64'(rtc_ns), 0);
    chk("set_roll_pps", 64'(pps), 1);
    @(negedge clk);
    chk("pps_one_clk", 64'(pps), 0);
    chk("after_roll_ns", 64'(rtc_ns), 8);

    set_time(16'h0, 32'd0, 32'd999_999_000);
    wr(8'h00, 32'h1);
    npps = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pps) npps++;
    end
    chk("count_pps", 64'(npps), 1);
    chk("count_sec", 64'(rtc_sec), 1);
    chk("count_ns", 64'(rtc_ns), 608);

    wr(8'h0C, 32'hFFFF_FFF0);
    set_time(16'h0, 32'd10, 32'd0);
    wr(8'h00, 32'h3);
    chk("adjn_ns", 64'(rtc_ns), 999_999_992);
    chk("adjn_sec", 64'(rtc_sec), 9);
    chk("adjn_pps", 64'(pps), 0);
    @(negedge clk);
    chk("adjn_next_ns", 64'(rtc_ns), 0);
    chk("adjn_next_sec", 64'(rtc_sec), 10);
    chk("adjn_next_pps", 64'(pps), 1);

    wr(8'h0C, 32'd100);
    set_time(16'h0, 32'd3, 32'd999_999_990);
    wr(8'h00, 32'h3);
    chk("adjp_ns", 64'(rtc_ns), 98);
    chk("adjp_sec", 64'(rtc_sec), 4);
    chk("adjp_pps", 64'(pps), 1);

    // ADJ alone, two edges after a plain SET
    wr(8'h0C, 32'hFFFF_FFD8);
    set_time(16'h0, 32'd10, 32'd0);
    wr(8'h00, 32'h1);
    wr(8'h00, 32'h2);
    chk("adj_only_ns", 64'(rtc_ns), 999_999_984);
    chk("adj_only_sec", 64'(rtc_sec), 9);

    wr(8'h08, 32'h0A80_0000);
    set_time(16'h0, 32'd0, 32'd0);
    wr(8'h00, 32'h5);
    chk("per_old_inc", 64'(rtc_ns), 8);
    @(negedge clk);
    chk("per_new_1", 64'(rtc_ns), 18);
    @(negedge clk);
    chk("per_new_2", 64'(rtc_ns), 29);
    wr(8'h08, 32'h0800_0000);
    wr(8'h00, 32'h4);

    set_time(16'h1, 32'd2, 32'd1000);
    wr(8'h00, 32'h1);
    chk("sec48", 64'(rtc_sec), 64'h1_0000_0002);
    wr(8'h00, 32'h8);
    rd(8'h48, rv); chk("snap_ns", 64'(rv), 1016);
    rd(8'h44, rv); chk("snap_lo", 64'(rv), 2);
    rd(8'h40, rv); chk("snap_hi", 64'(rv), 1);

    build(16'h88F7, 4'h0, 16'h1234, 60);
    set_time(16'h0, 32'h20, 32'd0);
    wr(8'h00, 32'h1);
    send(1'b0);
    rd(8'h20, rv); chk("rx_status", 64'(rv), 64'h1234_0001);
    rd(8'h2C, rv); chk("rx_ns", 64'(rv), 72);
    rd(8'h28, rv); chk("rx_lo", 64'(rv), 32'h20);
    rd(8'h24, rv); chk("rx_hi", 64'(rv), 0);
    wr(8'h00, 32'h10);
    rd(8'h20, rv); chk("rx_clear", 64'(rv), 64'h1234_0000);

    build(16'h0800, 4'h0, 16'h5555, 60);
    send(1'b0);
    rd(8'h20, rv); chk("rx_ipv4", 64'(rv), 64'h1234_0000);
    build(16'h88F7, 4'h0, 16'h7777, 40);
    send(1'b0);
    rd(8'h20, rv); chk("rx_trunc40", 64'(rv), 64'h1234_0000);
    build(16'h88F7, 4'hB, 16'h6666, 60);
    send(1'b0);
    rd(8'h20, rv); chk("rx_general", 64'(rv), 64'h1234_0000);
    build(16'h88F7, 4'h3, 16'hBEEF, 46);
    send(1'b0);
    rd(8'h20, rv); chk("rx_min46", 64'(rv), 64'hBEEF_0001);
    wr(8'h00, 32'h10);
    build(16'h88F7, 4'h0, 16'hAAAA, 45);
    send(1'b0);
    rd(8'h20, rv); chk("rx_len45", 64'(rv), 64'hBEEF_0000);

    build(16'h88F7, 4'h0, 16'h1234, 60);
    set_time(16'h0, 32'h30, 32'd0);
    wr(8'h00, 32'h1);
    send(1'b1);
    rd(8'h30, rv); chk("tx_status", 64'(rv), 64'h1234_0001);
    rd(8'h3C, rv); chk("tx_ns", 64'(rv), 136);
    rd(8'h38, rv); chk("tx_lo", 64'(rv), 32'h30);
    rd(8'h20, rv); chk("rx_isolated", 64'(rv), 64'hBEEF_0000);
    build(16'h88F7, 4'h0, 16'h4321, 60);
    send(1'b1);
    rd(8'h30, rv); chk("tx_overflow", 64'(rv), 64'h1234_0003);
    rd(8'h3C, rv); chk("tx_ns_kept", 64'(rv), 136);
    wr(8'h00, 32'h20);
    rd(8'h30, rv); chk("tx_clear", 64'(rv), 64'h1234_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
